// File: rtl/gpr_snapshot_sequencer_pkg.sv
// rtl/gpr_snapshot_sequencer_pkg.sv - shared encodings and header layout for the GPR snapshot sequencer
package gpr_snapshot_sequencer_pkg;

   localparam int DIAGNOSIS_EV_ID_WIDTH     = 16;
   localparam int DIAGNOSIS_TIMESTAMP_WIDTH = 32;
   localparam int GPR_IDX_WIDTH             = 5;

   localparam logic [1:0] KIND_HDR = 2'd0;
   localparam logic [1:0] KIND_TS  = 2'd1;
   localparam logic [1:0] KIND_GPR = 2'd2;

   // Header word: event id in the upper half, GPR count in the low six bits.
   localparam int HDR_ID_LSB    = 16;
   localparam int HDR_ID_WIDTH  = 16;
   localparam int HDR_CNT_LSB   = 0;
   localparam int HDR_CNT_WIDTH = 6;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_TS   = 3'd2,
      ST_RD   = 3'd3,
      ST_DATA = 3'd4
   } state_e;

   function automatic logic [31:0] hdr_word(input logic [HDR_ID_WIDTH-1:0]  id,
                                            input logic [HDR_CNT_WIDTH-1:0] cnt);
      logic [31:0] w;
      w = '0;
      w[HDR_ID_LSB  +: HDR_ID_WIDTH]  = id;
      w[HDR_CNT_LSB +: HDR_CNT_WIDTH] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/gpr_snapshot_sequencer_prio_enc32.sv
// rtl/gpr_snapshot_sequencer_prio_enc32.sv - lowest-set-bit encoder for a 32-bit request vector
module prio_enc32
   import gpr_snapshot_sequencer_pkg::*;
(
   input  logic [31:0]              req_i,
   output logic [GPR_IDX_WIDTH-1:0] idx_o,
   output logic                     any_o
);

   // Scanning downward lets the lowest set bit overwrite any higher match.
   always_comb begin
      idx_o = '0;
      any_o = |req_i;
      for (int i = 31; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = GPR_IDX_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/gpr_snapshot_sequencer.sv
// rtl/gpr_snapshot_sequencer.sv - walks selected GPRs on an event and streams a framed snapshot
module gpr_snapshot_sequencer
   import gpr_snapshot_sequencer_pkg::*;
#(
   parameter int EV_ID_WIDTH     = DIAGNOSIS_EV_ID_WIDTH,
   parameter int TIMESTAMP_WIDTH = DIAGNOSIS_TIMESTAMP_WIDTH,
   parameter int GPR_COUNT       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       event_valid_global,
   input  logic [EV_ID_WIDTH-1:0]     ev_id,
   input  logic [TIMESTAMP_WIDTH-1:0] ev_time,
   input  logic [GPR_COUNT-1:0]       bv_GPR,
   output logic                       gpr_rd_en,
   output logic [4:0]                 gpr_rd_addr,
   input  logic [31:0]                gpr_rd_data,
   output logic                       gpr_freeze,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_data,
   output logic [1:0]                 out_kind,
   output logic                       out_last,
   output logic                       busy,
   output logic [7:0]                 drop_count
);

   state_e                     state_q, state_d;
   logic [31:0]                pend_q, pend_d;
   logic [EV_ID_WIDTH-1:0]     id_q, id_d;
   logic [TIMESTAMP_WIDTH-1:0] time_q, time_d;
   logic [5:0]                 cnt_q, cnt_d;
   logic [31:0]                hold_q, hold_d;
   logic                       fresh_q, fresh_d;
   logic [7:0]                 drop_q, drop_d;

   logic [31:0]                bv_ext;
   logic [5:0]                 bv_pop;
   logic [GPR_IDX_WIDTH-1:0]   low_idx;
   logic                       pend_any;

   assign bv_ext = 32'(bv_GPR);

   always_comb begin
      bv_pop = '0;
      for (int i = 0; i < 32; i++) begin
         bv_pop = bv_pop + 6'(bv_ext[i]);
      end
   end

   prio_enc32 u_prio_enc32 (
      .req_i (pend_q),
      .idx_o (low_idx),
      .any_o (pend_any)
   );

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      id_d        = id_q;
      time_d      = time_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      fresh_d     = 1'b0;
      drop_d      = drop_q;
      out_valid   = 1'b0;
      out_data    = '0;
      out_kind    = KIND_HDR;
      out_last    = 1'b0;
      gpr_rd_en   = 1'b0;
      gpr_rd_addr = '0;

      if (event_valid_global && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (event_valid_global) begin
               pend_d  = bv_ext;
               id_d    = ev_id;
               time_d  = ev_time;
               cnt_d   = bv_pop;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            out_valid = 1'b1;
            out_data  = hdr_word(16'(id_q), cnt_q);
            out_kind  = KIND_HDR;
            if (out_ready) begin
               state_d = ST_TS;
            end
         end
         ST_TS: begin
            out_valid = 1'b1;
            out_data  = 32'(time_q);
            out_kind  = KIND_TS;
            out_last  = !pend_any;
            if (out_ready) begin
               state_d = pend_any ? ST_RD : ST_IDLE;
            end
         end
         ST_RD: begin
            gpr_rd_en   = 1'b1;
            gpr_rd_addr = low_idx;
            pend_d      = pend_q & ~(32'd1 << low_idx);
            fresh_d     = 1'b1;
            state_d     = ST_DATA;
         end
         ST_DATA: begin
            // Read data is only valid on the entry cycle; later stall cycles replay the held copy.
            out_valid = 1'b1;
            out_kind  = KIND_GPR;
            out_last  = !pend_any;
            out_data  = fresh_q ? gpr_rd_data : hold_q;
            if (fresh_q) begin
               hold_d = gpr_rd_data;
            end
            if (out_ready) begin
               state_d = pend_any ? ST_RD : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         id_q    <= '0;
         time_q  <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         fresh_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         id_q    <= id_d;
         time_q  <= time_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         fresh_q <= fresh_d;
         drop_q  <= drop_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign gpr_freeze = (state_q != ST_IDLE);
   assign drop_count = drop_q;

endmodule

// File: tb/tb_gpr_snapshot_sequencer.sv
// tb/tb_gpr_snapshot_sequencer.sv - randomized self-checking bench for gpr_snapshot_sequencer
module tb_gpr_snapshot_sequencer;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  kind;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        event_valid_global = 1'b0;
   logic [15:0] ev_id = '0;
   logic [31:0] ev_time = '0;
   logic [31:0] bv_GPR = '0;
   logic        gpr_rd_en;
   logic [4:0]  gpr_rd_addr;
   logic [31:0] gpr_rd_data = '0;
   logic        gpr_freeze;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [1:0]  out_kind;
   logic        out_last;
   logic        busy;
   logic [7:0]  drop_count;

   logic [31:0] mem [32];
   int          cyc = 0;
   int          ready_mode = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   word_t       obs_q[$];
   int          obs_cyc_q[$];
   int          addr_q[$];
   int          rd_cyc_q[$];
   logic        prev_stall = 1'b0;
   word_t       prev_w;

   gpr_snapshot_sequencer dut (
      .clk                (clk),
      .rst                (rst),
      .event_valid_global (event_valid_global),
      .ev_id              (ev_id),
      .ev_time            (ev_time),
      .bv_GPR             (bv_GPR),
      .gpr_rd_en          (gpr_rd_en),
      .gpr_rd_addr        (gpr_rd_addr),
      .gpr_rd_data        (gpr_rd_data),
      .gpr_freeze         (gpr_freeze),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_data           (out_data),
      .out_kind           (out_kind),
      .out_last           (out_last),
      .busy               (busy),
      .drop_count         (drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Shadow copy: synchronous read, garbage on cycles that follow no read strobe.
   always @(posedge clk) gpr_rd_data <= gpr_rd_en ? mem[gpr_rd_addr] : $urandom;

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_word", 64'({out_data, out_kind, out_last}), 64'(prev_w));
         end
         check("freeze_eq_busy", 64'(gpr_freeze), 64'(busy));
         if (gpr_rd_en) begin
            check("rd_en_while_busy", 64'(busy), 64'd1);
            addr_q.push_back(int'(gpr_rd_addr));
            rd_cyc_q.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            obs_q.push_back({out_data, out_kind, out_last});
            obs_cyc_q.push_back(cyc);
         end
         prev_stall <= out_valid && !out_ready;
         prev_w     <= {out_data, out_kind, out_last};
      end
   end

   task automatic clear_obs();
      obs_q.delete();
      obs_cyc_q.delete();
      addr_q.delete();
      rd_cyc_q.delete();
   endtask

   task automatic fill_mem(input bit seq);
      for (int n = 0; n < 32; n++)
         mem[n] = seq ? (32'hA0 + 32'(n)) : (($urandom() & 32'hFFFF_FF00) | 32'(n));
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, 64'({out_valid, out_data, out_kind, out_last, gpr_rd_en, gpr_rd_addr,
                      gpr_freeze, busy, drop_count}), 64'd0);
   endtask

   // Called at posedge+1; drives the event in the current cycle and checks the whole frame.
   task automatic do_frame(input logic [15:0] id, input logic [31:0] t, input logic [31:0] bv,
                           input int rmode, input int ex_lo, input int ex_hi, input bit ex_stall,
                           input bit settle);
      word_t exp_q[$];
      int    idx_q[$];
      int    need, rem, ev_cyc, n;
      need = 2;
      for (int i = 0; i < 32; i++) need += int'(bv[i]);
      exp_q.push_back({id, 10'b0, 6'(need - 2), 2'd0, 1'b0});
      exp_q.push_back({t, 2'd1, 1'(need == 2)});
      rem = need - 2;
      for (int i = 0; i < 32; i++) begin
         if (bv[i]) begin
            rem--;
            exp_q.push_back({mem[i], 2'd2, 1'(rem == 0)});
            idx_q.push_back(i);
         end
      end
      ready_mode = rmode;
      event_valid_global = 1'b1;
      ev_id = id;
      ev_time = t;
      bv_GPR = bv;
      ev_cyc = cyc;
      n = 0;
      while (obs_q.size() < need && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
         event_valid_global = (n >= ex_lo && n <= ex_hi);
         if (event_valid_global) begin
            ev_id = 16'($urandom);
            ev_time = $urandom;
            bv_GPR = $urandom;
         end
         ready_mode = (ex_stall && n <= ex_hi) ? 2 : rmode;
      end
      event_valid_global = 1'b0;
      if (settle) begin
         repeat (3) @(posedge clk);
         #1;
      end
      check("busy_after_frame", 64'(busy), 64'd0);
      check("frame_len", 64'(obs_q.size()), 64'(need));
      for (int k = 0; k < need && k < obs_q.size(); k++)
         check($sformatf("word%0d", k), 64'(obs_q[k]), 64'(exp_q[k]));
      check("rd_count", 64'(addr_q.size()), 64'(idx_q.size()));
      for (int k = 0; k < idx_q.size() && k < addr_q.size(); k++)
         check($sformatf("rd_addr%0d", k), 64'(addr_q[k]), 64'(idx_q[k]));
      if (rmode == 0 && !ex_stall && obs_cyc_q.size() >= 2) begin
         check("lat_hdr", 64'(obs_cyc_q[0]), 64'(ev_cyc + 1));
         check("lat_ts", 64'(obs_cyc_q[1]), 64'(ev_cyc + 2));
         if (need > 2 && obs_cyc_q.size() > 2 && rd_cyc_q.size() > 0) begin
            check("lat_rd0", 64'(rd_cyc_q[0]), 64'(ev_cyc + 3));
            check("lat_gpr0", 64'(obs_cyc_q[2]), 64'(ev_cyc + 4));
         end
         if (need > 3 && obs_cyc_q.size() > 3)
            check("lat_gpr1", 64'(obs_cyc_q[3]), 64'(ev_cyc + 6));
      end
      clear_obs();
   endtask

   initial begin
      logic [31:0] bv;
      fill_mem(1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset_state");
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_frame(16'd5, 32'h1234, 32'h0000_0000, 0, 0, -1, 1'b0, 1'b1);
      do_frame(16'h00A7, 32'h0BAD_F00D, 32'h8000_0005, 0, 0, -1, 1'b0, 1'b1);
      do_frame(16'h0F0F, $urandom, 32'hFFFF_FFFF, 1, 0, -1, 1'b0, 1'b1);

      for (int r = 0; r < 6; r++) begin
         fill_mem(1'b0);
         case ($urandom_range(0, 3))
            0:       bv = $urandom;
            1:       bv = $urandom & $urandom & $urandom;
            2:       bv = 32'd1 << $urandom_range(0, 31);
            default: bv = 32'd0;
         endcase
         do_frame(16'($urandom), $urandom, bv, int'($urandom_range(0, 1)), 0, -1, 1'b0, 1'b1);
      end

      do_frame(16'h0033, $urandom, $urandom | 32'h1, 0, 3, 3, 1'b0, 1'b1);
      check("drop_one", 64'(drop_count), 64'd1);
      do_frame(16'h0044, $urandom, 32'hFFFF_FFFF, 0, 1, 300, 1'b1, 1'b1);
      check("drop_saturate", 64'(drop_count), 64'd255);

      fill_mem(1'b0);
      ready_mode = 0;
      event_valid_global = 1'b1;
      ev_id = 16'h0077;
      ev_time = 32'h5555;
      bv_GPR = 32'h0000_0110;
      @(posedge clk);
      #1;
      event_valid_global = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #2;
      check("pre_reset_stall", 64'({out_valid, out_kind}), 64'({1'b1, 2'd2}));
      #1;
      rst = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
      @(posedge clk);
      #1;
      do_frame(16'h0123, $urandom, $urandom, 1, 0, -1, 1'b0, 1'b1);
      check("drop_after_reset", 64'(drop_count), 64'd0);

      do_frame(16'h0201, $urandom, 32'h0, 0, 2, 2, 1'b0, 1'b0);
      check("drop_on_final_hs", 64'(drop_count), 64'd1);
      do_frame(16'h0202, $urandom, $urandom, 0, 0, -1, 1'b0, 1'b1);
      check("drop_unchanged", 64'(drop_count), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
